// File: rtl/if_id_queue.sv
// if_id_queue
//   IF/ID pipeline stage with a DEPTH-entry instruction queue in front of a
//   registered ID-stage output. Fetch keeps handing over instructions while
//   ID is stalled. Delay-slot status is carried across bubbles, and a
//   requested delay-slot discard can be deferred until the instruction arrives.
//
//   Build option: define IFQ_BYPASS_EN to let a beat arriving at an empty,
//   unstalled queue load straight into ID (1-cycle IF-to-ID latency).
//   Without it, every beat goes through the queue (2-cycle minimum latency).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               drop everything, ID becomes a bubble (highest priority)
//   stall               ID stalled: id_* hold, no dequeue
//   clrslot             discard the next instruction destined for ID
//   if_valid/if_ready   fetch handshake (if_ready = queue not full)
//   if_pc/pcp4/inst/excp  fetch beat
//   id_isbranch         instruction currently in ID is a branch/jump
//   id_pc/pcp4/inst/excp  registered ID-stage outputs
//   id_inslot           ID instruction sits in a delay slot
//   id_null             ID holds a bubble
//   count               queue occupancy (ID register excluded)
module if_id_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                EXC_W    = 5,
  parameter logic [EXC_W-1:0]  EXC_NONE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         stall,
  input  logic                         clrslot,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic [ADDR_W-1:0]            if_pc,
  input  logic [ADDR_W-1:0]            if_pcp4,
  input  logic [DATA_W-1:0]            if_inst,
  input  logic [EXC_W-1:0]             if_excp,
  input  logic                         id_isbranch,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [ADDR_W-1:0]            id_pcp4,
  output logic [DATA_W-1:0]            id_inst,
  output logic [EXC_W-1:0]             id_excp,
  output logic                         id_inslot,
  output logic                         id_null,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcp4;
    logic [DATA_W-1:0] inst;
    logic [EXC_W-1:0]  excp;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_slot_pend;
  logic            r_drop_pend;

  logic [ADDR_W-1:0] r_id_pc;
  logic [ADDR_W-1:0] r_id_pcp4;
  logic [DATA_W-1:0] r_id_inst;
  logic [EXC_W-1:0]  r_id_excp;
  logic              r_id_inslot;
  logic              r_id_null;

  entry_t w_in;
  entry_t w_cand;
  logic   w_empty;
  logic   w_enq;
  logic   w_bypass;
  logic   w_cand_vld;
  logic   w_deq;
  logic   w_wr;
  logic   w_drop;
  logic   w_load;
  logic   w_branch_in_id;

  assign w_in     = '{pc: if_pc, pcp4: if_pcp4, inst: if_inst, excp: if_excp};
  assign w_empty  = (r_count == '0);
  assign if_ready = (r_count != CW'(DEPTH));
  assign w_enq    = if_valid && if_ready;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_enq && w_empty && !stall;
`else
  assign w_bypass = 1'b0;
`endif

  // A candidate is always consumed when ID advances, whether it is loaded or
  // discarded by a pending/immediate slot clear.
  assign w_cand_vld     = !stall && (!w_empty || w_bypass);
  assign w_cand         = w_empty ? w_in : r_mem[r_head];
  assign w_deq          = !flush && !stall && !w_empty;
  assign w_wr           = !flush && w_enq && !w_bypass;
  assign w_drop         = clrslot || r_drop_pend;
  assign w_load         = w_cand_vld && !w_drop;
  assign w_branch_in_id = id_isbranch && !r_id_null;

  // Queue storage: no reset needed, occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_mem[r_tail] <= w_in;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_tail <= r_tail + 1'b1;
      if (w_deq) r_head <= r_head + 1'b1;
      unique case ({w_wr, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ID register: load candidate, else bubble; stall holds everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_id_pc     <= '0;
      r_id_pcp4   <= '0;
      r_id_inst   <= '0;
      r_id_excp   <= EXC_NONE;
      r_id_inslot <= 1'b0;
      r_id_null   <= 1'b1;
    end else if (!stall) begin
      if (w_load) begin
        r_id_pc     <= w_cand.pc;
        r_id_pcp4   <= w_cand.pcp4;
        r_id_inst   <= w_cand.inst;
        r_id_excp   <= w_cand.excp;
        r_id_inslot <= w_branch_in_id || r_slot_pend;
        r_id_null   <= 1'b0;
      end else begin
        r_id_pc     <= '0;
        r_id_pcp4   <= '0;
        r_id_inst   <= '0;
        r_id_excp   <= EXC_NONE;
        r_id_inslot <= 1'b0;
        r_id_null   <= 1'b1;
      end
    end
  end

  // slot_pend remembers a branch that left ID before its delay slot arrived;
  // drop_pend remembers a slot discard that found nothing to discard yet.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_slot_pend <= 1'b0;
      r_drop_pend <= 1'b0;
    end else if (!stall) begin
      if (w_drop) begin
        r_slot_pend <= 1'b0;
        r_drop_pend <= !w_cand_vld;
      end else if (w_cand_vld) begin
        r_slot_pend <= 1'b0;
      end else if (w_branch_in_id) begin
        r_slot_pend <= 1'b1;
      end
    end
  end

  assign id_pc     = r_id_pc;
  assign id_pcp4   = r_id_pcp4;
  assign id_inst   = r_id_inst;
  assign id_excp   = r_id_excp;
  assign id_inslot = r_id_inslot;
  assign id_null   = r_id_null;
  assign count     = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue
//   Self-checking bench for if_id_queue (DEPTH=4). A stimulus table covers
//   reset, fill-under-stall, backpressure and in-order drain; short
//   hand-written sequences cover latency, delay-slot tracking, clrslot,
//   flush and reset with pending state. Latency-dependent expectations
//   follow IFQ_BYPASS_EN.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int EW    = 5;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, stall, clrslot, if_valid, if_ready, id_isbranch;
  logic [AW-1:0] if_pc, if_pcp4, id_pc, id_pcp4;
  logic [DW-1:0] if_inst, id_inst;
  logic [EW-1:0] if_excp, id_excp;
  logic          id_inslot, id_null;
  logic [2:0]    count;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  if_id_queue #(
    .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .EXC_W(EW), .EXC_NONE(5'd0)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .clrslot(clrslot),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_pcp4(if_pcp4),
    .if_inst(if_inst), .if_excp(if_excp), .id_isbranch(id_isbranch),
    .id_pc(id_pc), .id_pcp4(id_pcp4), .id_inst(id_inst), .id_excp(id_excp),
    .id_inslot(id_inslot), .id_null(id_null), .count(count)
  );

  function automatic logic [31:0] f_inst(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [4:0] f_excp(input logic [31:0] pc);
    return pc[8:4];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic e_null, input logic [31:0] e_pc,
                        input logic [31:0] e_inst, input logic e_slot);
    chk({tag, ".null"},   32'(id_null),   32'(e_null));
    chk({tag, ".inslot"}, 32'(id_inslot), 32'(e_slot));
    chk({tag, ".pc"},     id_pc,          e_null ? 32'h0 : e_pc);
    chk({tag, ".pcp4"},   id_pcp4,        e_null ? 32'h0 : e_pc + 32'd4);
    chk({tag, ".inst"},   id_inst,        e_null ? 32'h0 : e_inst);
    chk({tag, ".excp"},   32'(id_excp),   e_null ? 32'h0 : 32'(f_excp(e_pc)));
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_pcp4  = pc + 32'd4;
    if_inst  = f_inst(pc);
    if_excp  = f_excp(pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, then wait (bounded) for it to show up in ID.
  task automatic deliver(input string tag, input logic [31:0] pc, input logic e_slot);
    set_in(1'b1, pc);
    step();
    set_in(1'b0, 32'h0);
    for (int unsigned i = 0; i < 3 && id_null; i++) step();
    chk_id(tag, 1'b0, pc, f_inst(pc), e_slot);
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        valid;
    logic [31:0] pc;
    logic        e_null;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [31:0] pc,
                              input logic en, input logic [31:0] epc, input logic [2:0] ec,
                              input logic er);
    vec_t t;
    t.rst = r; t.stall = s; t.valid = v; t.pc = pc;
    t.e_null = en; t.e_pc = epc; t.e_cnt = ec; t.e_rdy = er;
    return t;
  endfunction

  vec_t tbl [13];

  initial begin
    //            rst stall vld  pc          null  id_pc       cnt  rdy
    tbl[0]  = mk(1, 0, 0, 32'h0,    1, 32'h0,    3'd0, 1);
    tbl[1]  = mk(0, 1, 1, 32'h100,  1, 32'h0,    3'd1, 1);
    tbl[2]  = mk(0, 1, 1, 32'h104,  1, 32'h0,    3'd2, 1);
    tbl[3]  = mk(0, 1, 1, 32'h108,  1, 32'h0,    3'd3, 1);
    tbl[4]  = mk(0, 1, 1, 32'h10C,  1, 32'h0,    3'd4, 0);
    tbl[5]  = mk(0, 1, 1, 32'h110,  1, 32'h0,    3'd4, 0);
    tbl[6]  = mk(0, 1, 1, 32'h110,  1, 32'h0,    3'd4, 0);
    tbl[7]  = mk(0, 0, 1, 32'h110,  0, 32'h100,  3'd3, 1);
    tbl[8]  = mk(0, 0, 1, 32'h110,  0, 32'h104,  3'd3, 1);
    tbl[9]  = mk(0, 0, 0, 32'h0,    0, 32'h108,  3'd2, 1);
    tbl[10] = mk(0, 0, 0, 32'h0,    0, 32'h10C,  3'd1, 1);
    tbl[11] = mk(0, 0, 0, 32'h0,    0, 32'h110,  3'd0, 1);
    tbl[12] = mk(0, 0, 0, 32'h0,    1, 32'h0,    3'd0, 1);

    rst = 1'b1; flush = 1'b0; stall = 1'b0; clrslot = 1'b0; id_isbranch = 1'b0;
    set_in(1'b0, 32'h0);

    for (int unsigned i = 0; i < 13; i++) begin
      rst   = tbl[i].rst;
      stall = tbl[i].stall;
      set_in(tbl[i].valid, tbl[i].pc);
      step();
      chk_id($sformatf("vec%0d", i), tbl[i].e_null, tbl[i].e_pc, f_inst(tbl[i].e_pc), 1'b0);
      chk($sformatf("vec%0d.count", i), 32'(count),    32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d.ready", i), 32'(if_ready), 32'(tbl[i].e_rdy));
    end
    rst = 1'b0; stall = 1'b0;

    // First-instruction latency.
    set_in(1'b1, 32'hBFC0_0000);
    if_inst = 32'h2408_0001;
    step();
    set_in(1'b0, 32'h0);
    if (!BYP) begin
      chk("lat.cnt_mid",  32'(count),   32'd1);
      chk("lat.null_mid", 32'(id_null), 32'd1);
      step();
    end
    chk_id("lat", 1'b0, 32'hBFC0_0000, 32'h2408_0001, 1'b0);
    chk("lat.count", 32'(count), 32'd0);

    // Branch leaves ID before its delay slot arrives.
    deliver("br", 32'h200, 1'b0);
    id_isbranch = 1'b1;
    step();
    id_isbranch = 1'b0;
    chk_id("br.bub1", 1'b1, 32'h0, 32'h0, 1'b0);
    step();
    chk_id("br.bub2", 1'b1, 32'h0, 32'h0, 1'b0);
    deliver("br.slot", 32'h204, 1'b1);

    // clrslot on empty queue discards the next arrival.
    clrslot = 1'b1;
    step();
    clrslot = 1'b0;
    chk("clr.null0", 32'(id_null), 32'd1);
    set_in(1'b1, 32'h308);
    step();
    set_in(1'b0, 32'h0);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk($sformatf("clr.null%0d", i + 1), 32'(id_null), 32'd1);
    end
    chk("clr.count", 32'(count), 32'd0);
    deliver("clr.next", 32'h30C, 1'b0);

    // Flush with three queued entries while stalled.
    stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h400 + 32'(i * 4));
      step();
    end
    chk("fl.count_pre", 32'(count), 32'd3);
    chk("fl.hold_pc",   id_pc,      32'h30C);
    flush = 1'b1;
    set_in(1'b1, 32'h40C);
    step();
    flush = 1'b0; stall = 1'b0;
    set_in(1'b0, 32'h0);
    chk_id("fl", 1'b1, 32'h0, 32'h0, 1'b0);
    chk("fl.count", 32'(count),    32'd0);
    chk("fl.ready", 32'(if_ready), 32'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      chk($sformatf("fl.after%0d.null", i), 32'(id_null), 32'd1);
    end

    // Reset with queued entries and a pending drop.
    clrslot = 1'b1;
    step();
    clrslot = 1'b0;
    stall = 1'b1;
    set_in(1'b1, 32'h600); step();
    set_in(1'b1, 32'h604); step();
    chk("rs.count_pre", 32'(count), 32'd2);
    stall = 1'b0; rst = 1'b1;
    set_in(1'b0, 32'h0);
    step();
    rst = 1'b0;
    chk_id("rs", 1'b1, 32'h0, 32'h0, 1'b0);
    chk("rs.count", 32'(count),    32'd0);
    chk("rs.ready", 32'(if_ready), 32'd1);
    deliver("rs.next", 32'h500, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
